// File: rtl/wind_scheduler_if.sv
// Control-panel bundle for wind_scheduler: button/tick/power inputs and status outputs.
// master drives the panel inputs, slave is the scheduler itself.
interface wind_scheduler_if;
   logic       tick_1s;
   logic       power_on;
   logic       menu_btn;
   logic       mode1_btn;
   logic       mode2_btn;
   logic       mode3_btn;
   logic       clean_btn;
   logic [2:0] mode_state;
   logic [4:0] led;
   logic [7:0] countdown;
   logic       menu_active;
   logic       hurricane_used;
   logic       clean_done;

   modport master (
      output tick_1s, power_on, menu_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn,
      input  mode_state, led, countdown, menu_active, hurricane_used, clean_done
   );

   modport slave (
      input  tick_1s, power_on, menu_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn,
      output mode_state, led, countdown, menu_active, hurricane_used, clean_done
   );
endinterface

// File: rtl/wind_scheduler.sv
// Fan mode scheduler: standby/menu navigation, three speed levels with a one-shot
// timed hurricane level, a timed exit run-on and a timed self-clean cycle.
module wind_scheduler #(
   parameter int unsigned HURRICANE_SEC = 60,
   parameter int unsigned EXIT_SEC      = 60,
   parameter int unsigned CLEAN_SEC     = 180
) (
   input logic              clk,
   input logic              rst,
   wind_scheduler_if.slave  bus
);

   localparam logic [7:0] HUR_CNT   = 8'(HURRICANE_SEC);
   localparam logic [7:0] EXIT_CNT  = 8'(EXIT_SEC);
   localparam logic [7:0] CLEAN_CNT = 8'(CLEAN_SEC);

   typedef enum logic [2:0] {
      S_OFF, S_STANDBY, S_MENU, S_L1, S_L2, S_L3, S_EXIT, S_CLEAN
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       used_q, used_d;
   logic       done_q, done_d;
   logic [2:0] ms_q, ms_d;
   logic [4:0] led_q, led_d;
   logic       menu_q, menu_d;

   logic tick, menu, m1, m2, m3, cln;
   assign tick = bus.tick_1s;
   assign menu = bus.menu_btn;
   assign m1   = bus.mode1_btn;
   assign m2   = bus.mode2_btn;
   assign m3   = bus.mode3_btn;
   assign cln  = bus.clean_btn;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      used_d  = used_q;
      done_d  = 1'b0;
      if (!bus.power_on) begin
         state_d = S_OFF;
         cnt_d   = '0;
         used_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_OFF:     state_d = S_STANDBY;
            S_STANDBY: if (menu) state_d = S_MENU;
            S_MENU, S_L1, S_L2: begin
               // Fixed priority; a blocked mode3 is consumed and never falls to clean.
               if (menu)    state_d = S_STANDBY;
               else if (m1) state_d = S_L1;
               else if (m2) state_d = S_L2;
               else if (m3) begin
                  if (!used_q) begin
                     state_d = S_L3;
                     cnt_d   = HUR_CNT;
                     used_d  = 1'b1;
                  end
               end else if (cln && state_q == S_MENU) begin
                  state_d = S_CLEAN;
                  cnt_d   = CLEAN_CNT;
               end
            end
            S_L3: begin
               if (menu) begin
                  state_d = S_EXIT;
                  cnt_d   = EXIT_CNT;
               end else if (tick) begin
                  if (cnt_q <= 8'd1) begin
                     state_d = S_L2;
                     cnt_d   = '0;
                  end else cnt_d = cnt_q - 8'd1;
               end
            end
            S_EXIT, S_CLEAN: begin
               if (tick) begin
                  if (cnt_q <= 8'd1) begin
                     state_d = S_STANDBY;
                     cnt_d   = '0;
                     done_d  = (state_q == S_CLEAN);
                  end else cnt_d = cnt_q - 8'd1;
               end
            end
            default: begin
               state_d = S_OFF;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Status outputs are decoded from the next state so they register alongside it.
   always_comb begin
      ms_d   = 3'b000;
      led_d  = 5'b00000;
      menu_d = (state_d == S_MENU);
      case (state_d)
         S_STANDBY, S_MENU: led_d = 5'b00001;
         S_L1:   begin ms_d = 3'b001; led_d = 5'b00010; end
         S_L2:   begin ms_d = 3'b010; led_d = 5'b00100; end
         S_L3, S_EXIT: begin ms_d = 3'b011; led_d = 5'b01000; end
         S_CLEAN: begin ms_d = 3'b100; led_d = 5'b10000; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
         used_q  <= 1'b0;
         done_q  <= 1'b0;
         ms_q    <= '0;
         led_q   <= '0;
         menu_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         used_q  <= used_d;
         done_q  <= done_d;
         ms_q    <= ms_d;
         led_q   <= led_d;
         menu_q  <= menu_d;
      end
   end

   assign bus.mode_state     = ms_q;
   assign bus.led            = led_q;
   assign bus.countdown      = cnt_q;
   assign bus.menu_active    = menu_q;
   assign bus.hurricane_used = used_q;
   assign bus.clean_done     = done_q;

endmodule

// File: tb/tb_wind_scheduler.sv
// Directed vector bench for wind_scheduler with short timers (3/2/4 seconds).
module tb_wind_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wind_scheduler_if bus ();

   wind_scheduler #(
      .HURRICANE_SEC (3),
      .EXIT_SEC      (2),
      .CLEAN_SEC     (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       pwr, mn, m1, m2, m3, cl, tk;
      logic [2:0] ms;
      logic [4:0] led;
      logic [7:0] cd;
      logic       ma, hu, dn;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(input logic pwr, mn, m1, m2, m3, cl, tk,
                               input logic [2:0] ms, input logic [4:0] led,
                               input logic [7:0] cd, input logic ma, hu, dn);
      vec_t v;
      v.pwr = pwr; v.mn = mn; v.m1 = m1; v.m2 = m2; v.m3 = m3; v.cl = cl; v.tk = tk;
      v.ms = ms; v.led = led; v.cd = cd; v.ma = ma; v.hu = hu; v.dn = dn;
      return v;
   endfunction

   task automatic drive(input logic pwr, mn, m1, m2, m3, cl, tk);
      @(negedge clk);
      bus.power_on  = pwr;
      bus.menu_btn  = mn;
      bus.mode1_btn = m1;
      bus.mode2_btn = m2;
      bus.mode3_btn = m3;
      bus.clean_btn = cl;
      bus.tick_1s   = tk;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [2:0] ms, input logic [4:0] led,
                        input logic [7:0] cd, input logic ma, hu, dn);
      logic [18:0] act, exp;
      act = {bus.mode_state, bus.led, bus.countdown, bus.menu_active,
             bus.hurricane_used, bus.clean_done};
      exp = {ms, led, cd, ma, hu, dn};
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got ms=%b led=%b cd=%0d ma=%b hu=%b dn=%b, want ms=%b led=%b cd=%0d ma=%b hu=%b dn=%b",
                  name, bus.mode_state, bus.led, bus.countdown, bus.menu_active,
                  bus.hurricane_used, bus.clean_done, ms, led, cd, ma, hu, dn);
      end
   endtask

   initial begin
      bus.power_on = 1'b0; bus.menu_btn = 1'b0; bus.mode1_btn = 1'b0;
      bus.mode2_btn = 1'b0; bus.mode3_btn = 1'b0; bus.clean_btn = 1'b0;
      bus.tick_1s = 1'b0;

      //            pwr mn m1 m2 m3 cl tk   ms      led        cd  ma hu dn
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 5'b00001, 8'd0, 0, 0, 0)); // 0 OFF->STANDBY
      vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 3'b000, 5'b00001, 8'd0, 0, 0, 0)); // 1 standby ignores
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3'b000, 5'b00001, 8'd0, 1, 0, 0)); // 2 MENU
      vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 3'b010, 5'b00100, 8'd0, 0, 0, 0)); // 3 L2
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 3'b001, 5'b00010, 8'd0, 0, 0, 0)); // 4 L1
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3'b000, 5'b00001, 8'd0, 0, 0, 0)); // 5 STANDBY
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3'b000, 5'b00001, 8'd0, 1, 0, 0)); // 6 MENU
      vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 3'b011, 5'b01000, 8'd3, 0, 1, 0)); // 7 L3, no dec
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3'b011, 5'b01000, 8'd2, 0, 1, 0)); // 8
      vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 3'b011, 5'b01000, 8'd2, 0, 1, 0)); // 9 L3 ignores
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3'b011, 5'b01000, 8'd1, 0, 1, 0)); // 10
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3'b010, 5'b00100, 8'd0, 0, 1, 0)); // 11 timeout->L2
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3'b000, 5'b00001, 8'd0, 0, 1, 0)); // 12
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3'b000, 5'b00001, 8'd0, 1, 1, 0)); // 13 MENU
      vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 3'b000, 5'b00001, 8'd0, 1, 1, 0)); // 14 mode3 blocked
      vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 3'b000, 5'b00001, 8'd0, 1, 1, 0)); // 15 no fall-through
      vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 3'b010, 5'b00100, 8'd0, 0, 1, 0)); // 16 L2
      vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 3'b010, 5'b00100, 8'd0, 0, 1, 0)); // 17 L2 blocked/clean
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 3'b000, 5'b00000, 8'd0, 0, 0, 0)); // 18 power off
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 5'b00001, 8'd0, 0, 0, 0)); // 19
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3'b000, 5'b00001, 8'd0, 1, 0, 0)); // 20
      vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 3'b011, 5'b01000, 8'd3, 0, 1, 0)); // 21 L3 again
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3'b011, 5'b01000, 8'd2, 0, 1, 0)); // 22
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 3'b011, 5'b01000, 8'd2, 0, 1, 0)); // 23 menu beats tick
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 3'b011, 5'b01000, 8'd2, 0, 1, 0)); // 24 EXIT ignores
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3'b011, 5'b01000, 8'd1, 0, 1, 0)); // 25
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3'b000, 5'b00001, 8'd0, 0, 1, 0)); // 26 ->STANDBY
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3'b000, 5'b00001, 8'd0, 1, 1, 0)); // 27
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 3'b100, 5'b10000, 8'd4, 0, 1, 0)); // 28 CLEAN
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 3'b100, 5'b10000, 8'd3, 0, 1, 0)); // 29
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3'b100, 5'b10000, 8'd2, 0, 1, 0)); // 30
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 3'b100, 5'b10000, 8'd1, 0, 1, 0)); // 31
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3'b000, 5'b00001, 8'd0, 0, 1, 1)); // 32 clean_done
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 5'b00001, 8'd0, 0, 1, 0)); // 33 pulse ends
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 3'b000, 5'b00001, 8'd0, 1, 1, 0)); // 34
      vecs.push_back(mk(1, 0, 1, 0, 1, 1, 0, 3'b001, 5'b00010, 8'd0, 0, 1, 0)); // 35 mode1 wins
      vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 3'b000, 5'b00001, 8'd0, 0, 1, 0)); // 36 menu wins

      // Reset held with power and a button active
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      check("reset", 3'b000, 5'b00000, 8'd0, 0, 0, 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].pwr, vecs[i].mn, vecs[i].m1, vecs[i].m2, vecs[i].m3, vecs[i].cl, vecs[i].tk);
         check($sformatf("vec%0d", i), vecs[i].ms, vecs[i].led, vecs[i].cd,
               vecs[i].ma, vecs[i].hu, vecs[i].dn);
      end

      // Power drop mid-CLEAN after a hurricane run
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 0, 0);
      check("l3_before_off", 3'b011, 5'b01000, 8'd3, 0, 1, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 0, 1);
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 1);
      check("clean_mid", 3'b100, 5'b10000, 8'd3, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 1);
      check("clean_pwr_off", 3'b000, 5'b00000, 8'd0, 0, 0, 0);

      // Synchronous reset in L3 at countdown 2
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 1);
      check("l3_cd2", 3'b011, 5'b01000, 8'd2, 0, 1, 0);
      rst = 1'b1;
      drive(1, 0, 0, 0, 0, 0, 1);
      check("rst_mid_l3", 3'b000, 5'b00000, 8'd0, 0, 0, 0);
      rst = 1'b0;
      drive(1, 0, 0, 0, 0, 0, 0);
      check("after_rst", 3'b000, 5'b00001, 8'd0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wind_scheduler.md
WIND_SCHEDULER -- requirements
Module: wind_scheduler

Interface
REQ-001 Parameter HURRICANE_SEC, default 60, level-3 run time in seconds.
REQ-002 Parameter EXIT_SEC, default 60, level-3 run-on after menu exit, in seconds.
REQ-003 Parameter CLEAN_SEC, default 180, self-clean run time in seconds; all parameters SHALL be 1..255.
REQ-004 clk  input  1  system clock; sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 tick_1s  input  1  one-cycle strobe, once per second.
REQ-007 power_on  input  1  machine on level; low forces OFF.
REQ-008 menu_btn  input  1  one-cycle debounced pulse.
REQ-009 mode1_btn, mode2_btn, mode3_btn, clean_btn  input  1 each  one-cycle debounced pulses.
REQ-010 mode_state  output  3  000 off/standby/menu, 001 L1, 010 L2, 011 L3, 100 clean.
REQ-011 led  output  5  one-hot status: OFF 00000, STANDBY/MENU 00001, L1 00010, L2 00100, L3 or EXIT 01000, CLEAN 10000.
REQ-012 countdown  output  8  seconds remaining in L3/EXIT/CLEAN, else 0.
REQ-013 menu_active  output  1  high only in MENU.
REQ-014 hurricane_used  output  1  level 3 consumed this power cycle.
REQ-015 clean_done  output  1  one-cycle pulse on CLEAN completion.

Function
REQ-016 States SHALL be OFF, STANDBY, MENU, L1, L2, L3, EXIT, CLEAN; all outputs registered, updating the cycle after the causing input.
REQ-017 power_on low in any state SHALL go to OFF next cycle, clearing countdown and hurricane_used; overrides all buttons.
REQ-018 OFF -> STANDBY on first cycle with power_on high.
REQ-019 STANDBY: menu_btn -> MENU; other buttons ignored.
REQ-020 MENU: mode1 -> L1, mode2 -> L2, mode3 -> L3 (only if hurricane_used=0, else stay MENU), clean -> CLEAN, menu_btn -> STANDBY.
REQ-021 Simultaneous buttons SHALL resolve by priority menu > mode1 > mode2 > mode3 > clean; a blocked mode3 SHALL NOT fall through to clean.
REQ-022 L1/L2: mode1 -> L1, mode2 -> L2, mode3 -> L3 if hurricane_used=0, menu_btn -> STANDBY; clean ignored.
REQ-023 L3 entry SHALL load countdown=HURRICANE_SEC and set hurricane_used=1; tick_1s on entry cycle SHALL NOT decrement.
REQ-024 L3/EXIT/CLEAN: each tick_1s decrements countdown; tick with countdown=1 ends the phase and sets countdown=0.
REQ-025 L3 end by timeout -> L2; menu_btn in L3 -> EXIT with countdown=EXIT_SEC (menu beats simultaneous tick); other buttons ignored.
REQ-026 EXIT: mode_state stays 011; all buttons ignored; end -> STANDBY.
REQ-027 CLEAN: countdown=CLEAN_SEC at entry; all buttons ignored; end -> STANDBY with clean_done high exactly one cycle.
REQ-028 countdown SHALL never wrap below 0; unreachable state codes SHALL recover to OFF next cycle.

Reset
REQ-029 rst high SHALL, at the next edge, set state OFF, mode_state=000, led=00000, countdown=0, menu_active=0, hurricane_used=0, clean_done=0, regardless of other inputs, including mid-countdown.
REQ-030 rst SHALL dominate power_on; after rst falls, OFF -> STANDBY follows REQ-018.

Verification (HURRICANE_SEC=3, EXIT_SEC=2, CLEAN_SEC=4)
REQ-031 power_on=1, menu, mode2 -> mode_state=010, led=00100; mode1 -> 001, led=00010; menu -> 000, led=00001.
REQ-032 menu, mode3, 3 ticks -> countdown 3,2,1,0, then mode_state=010, hurricane_used=1; menu, menu, mode3 -> stays MENU, mode_state=000.
REQ-033 L3 at countdown=2, menu_btn and tick same cycle -> EXIT, countdown=2, mode_state=011; 2 ticks -> STANDBY, led=00001.
REQ-034 menu, clean; mode1 during CLEAN ignored; 4 ticks -> STANDBY, clean_done one cycle, countdown=0.
REQ-035 power_on low during CLEAN -> OFF, led=00000, hurricane_used=0; rst during L3 countdown=2 -> all outputs at reset values next cycle.
REQ-036 menu with mode1+mode3+clean same cycle in MENU -> L1 only; MENU with mode3+clean and hurricane_used=1 -> stays MENU.
